// File: rtl/id_ex_stage.sv
// id_ex_stage: registered ID/EX pipeline stage feeding alu_32bit.
// Decodes MIPS opcode/funct into the 3-bit ALU select, extends immediates,
// forwards from EX/MEM and MEM/WB, inserts load-use bubbles and honours
// stall/flush. Every ex_* output comes straight from a flop.
// Optional build macro: ID_EX_STALL_CNT_EN adds a saturating 32-bit count of
// cycles in which decode offered an instruction that was not accepted.
module id_ex_stage #(
   parameter int DATA_W = 32,
   parameter int REG_AW = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   output logic              id_ready,
   input  logic [5:0]        id_opcode,
   input  logic [5:0]        id_funct,
   input  logic [REG_AW-1:0] id_rs_addr,
   input  logic [REG_AW-1:0] id_rt_addr,
   input  logic [REG_AW-1:0] id_rd_addr,
   input  logic [DATA_W-1:0] id_rs_data,
   input  logic [DATA_W-1:0] id_rt_data,
   input  logic [15:0]       id_imm,
   input  logic              exm_reg_write,
   input  logic [REG_AW-1:0] exm_rd,
   input  logic [DATA_W-1:0] exm_result,
   input  logic              wb_reg_write,
   input  logic [REG_AW-1:0] wb_rd,
   input  logic [DATA_W-1:0] wb_result,
   input  logic              ex_stall,
   input  logic              flush,
`ifdef ID_EX_STALL_CNT_EN
   output logic [31:0]       stall_cnt,
`endif
   output logic              ex_valid,
   output logic [DATA_W-1:0] ex_a,
   output logic [DATA_W-1:0] ex_b,
   output logic [2:0]        ex_sel,
   output logic [DATA_W-1:0] ex_store_data,
   output logic [REG_AW-1:0] ex_rd,
   output logic              ex_reg_write,
   output logic              ex_mem_read,
   output logic              ex_mem_write,
   output logic              ex_illegal
);

   typedef enum logic [2:0] {
      SEL_AND = 3'b000,
      SEL_OR  = 3'b001,
      SEL_ADD = 3'b100,
      SEL_SUB = 3'b101,
      SEL_XOR = 3'b110
   } alu_sel_e;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_BNE   = 6'h05;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ADDIU = 6'h09;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_XORI  = 6'h0E;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   typedef struct packed {
      logic              valid;
      logic [DATA_W-1:0] a;
      logic [DATA_W-1:0] b;
      logic [2:0]        sel;
      logic [DATA_W-1:0] store_data;
      logic [REG_AW-1:0] rd;
      logic              reg_write;
      logic              mem_read;
      logic              mem_write;
      logic              illegal;
   } ex_t;

   ex_t ex_q, ex_d;

   alu_sel_e          dec_sel;
   logic              dec_b_imm, dec_zext, dec_uses_rt;
   logic              dec_wr_rt, dec_wr_rd, dec_mem_rd, dec_mem_wr, dec_illegal;
   logic [DATA_W-1:0] imm_ext, rs_fwd, rt_fwd;
   logic [REG_AW-1:0] dest;
   logic              hazard, capture;

   // EX/MEM wins over MEM/WB; register 0 is never forwarded.
   function automatic logic [DATA_W-1:0] fwd(
      input logic [REG_AW-1:0] src,
      input logic [DATA_W-1:0] rf_data,
      input logic              exm_we,
      input logic [REG_AW-1:0] exm_dst,
      input logic [DATA_W-1:0] exm_val,
      input logic              wb_we,
      input logic [REG_AW-1:0] wb_dst,
      input logic [DATA_W-1:0] wb_val
   );
      if (exm_we && exm_dst != '0 && exm_dst == src)   return exm_val;
      else if (wb_we && wb_dst != '0 && wb_dst == src) return wb_val;
      else                                             return rf_data;
   endfunction

   // Instruction decode: ALU select, operand-b source, destination and memory controls.
   always_comb begin
      // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
      dec_sel     = SEL_ADD;
      dec_b_imm   = 1'b0;
      dec_zext    = 1'b0;
      dec_uses_rt = 1'b0;
      dec_wr_rt   = 1'b0;
      dec_wr_rd   = 1'b0;
      dec_mem_rd  = 1'b0;
      dec_mem_wr  = 1'b0;
      dec_illegal = 1'b0;
      case (id_opcode)
         OP_RTYPE: begin
            dec_uses_rt = 1'b1;
            dec_wr_rd   = 1'b1;
            case (id_funct)
               6'h20, 6'h21: dec_sel = SEL_ADD;
               6'h22, 6'h23: dec_sel = SEL_SUB;
               6'h24:        dec_sel = SEL_AND;
               6'h25:        dec_sel = SEL_OR;
               6'h26:        dec_sel = SEL_XOR;
               default: begin
                  dec_wr_rd   = 1'b0;
                  dec_illegal = 1'b1;
               end
            endcase
         end
         OP_ADDI, OP_ADDIU: begin
            dec_b_imm = 1'b1;
            dec_wr_rt = 1'b1;
         end
         OP_ANDI: begin
            dec_sel   = SEL_AND;
            dec_b_imm = 1'b1;
            dec_zext  = 1'b1;
            dec_wr_rt = 1'b1;
         end
         OP_ORI: begin
            dec_sel   = SEL_OR;
            dec_b_imm = 1'b1;
            dec_zext  = 1'b1;
            dec_wr_rt = 1'b1;
         end
         OP_XORI: begin
            dec_sel   = SEL_XOR;
            dec_b_imm = 1'b1;
            dec_zext  = 1'b1;
            dec_wr_rt = 1'b1;
         end
         OP_LW: begin
            dec_b_imm  = 1'b1;
            dec_wr_rt  = 1'b1;
            dec_mem_rd = 1'b1;
         end
         OP_SW: begin
            dec_b_imm   = 1'b1;
            dec_uses_rt = 1'b1;
            dec_mem_wr  = 1'b1;
         end
         OP_BEQ, OP_BNE: begin
            dec_sel     = SEL_SUB;
            dec_uses_rt = 1'b1;
         end
         default: dec_illegal = 1'b1;
      endcase
   end

   // Operand forwarding, immediate extension, load-use hazard and handshake.
   always_comb begin
      rs_fwd  = fwd(id_rs_addr, id_rs_data, exm_reg_write, exm_rd, exm_result,
                    wb_reg_write, wb_rd, wb_result);
      rt_fwd  = fwd(id_rt_addr, id_rt_data, exm_reg_write, exm_rd, exm_result,
                    wb_reg_write, wb_rd, wb_result);
      imm_ext = dec_zext ? {{(DATA_W-16){1'b0}}, id_imm}
                         : {{(DATA_W-16){id_imm[15]}}, id_imm};
      dest    = (id_opcode == OP_RTYPE) ? id_rd_addr : id_rt_addr;
      hazard  = ex_q.valid && ex_q.mem_read && (ex_q.rd != '0) &&
                ((ex_q.rd == id_rs_addr) || (ex_q.rd == id_rt_addr && dec_uses_rt));
      id_ready = !ex_stall && !hazard;
      capture  = id_valid && id_ready;
   end

   // Stage next state: flush > stall > capture > bubble.
   always_comb begin
      ex_d = ex_q;
      if (flush || (!ex_stall && !capture)) begin
         ex_d.valid     = 1'b0;
         ex_d.reg_write = 1'b0;
         ex_d.mem_read  = 1'b0;
         ex_d.mem_write = 1'b0;
         ex_d.illegal   = 1'b0;
      end else if (capture) begin
         ex_d.valid      = 1'b1;
         ex_d.a          = rs_fwd;
         ex_d.b          = dec_b_imm ? imm_ext : rt_fwd;
         ex_d.sel        = dec_sel;
         ex_d.store_data = rt_fwd;
         ex_d.rd         = dest;
         ex_d.reg_write  = (dec_wr_rd || dec_wr_rt) && (dest != '0);
         ex_d.mem_read   = dec_mem_rd;
         ex_d.mem_write  = dec_mem_wr;
         ex_d.illegal    = dec_illegal;
      end
   end

   // Stage register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      if (!rst_n) ex_q <= '0;
      else        ex_q <= ex_d;
   end

   assign ex_valid      = ex_q.valid;
   assign ex_a          = ex_q.a;
   assign ex_b          = ex_q.b;
   assign ex_sel        = ex_q.sel;
   assign ex_store_data = ex_q.store_data;
   assign ex_rd         = ex_q.rd;
   assign ex_reg_write  = ex_q.reg_write;
   assign ex_mem_read   = ex_q.mem_read;
   assign ex_mem_write  = ex_q.mem_write;
   assign ex_illegal    = ex_q.illegal;

`ifdef ID_EX_STALL_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;

   // Saturating count of offered-but-refused cycles.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (id_valid && !id_ready && stall_cnt_q != 32'hFFFF_FFFF)
         stall_cnt_d = stall_cnt_q + 32'd1;
   end

   // Stall counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_cnt_q <= '0;
      else        stall_cnt_q <= stall_cnt_d;
   end

   assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed self-checking bench for id_ex_stage.
// Inputs change on the falling edge; registered outputs are sampled 1 time
// unit after the rising edge, id_ready 1 time unit after inputs change.
module tb_id_ex_stage;

   logic        clk, rst_n;
   logic        id_valid, id_ready;
   logic [5:0]  id_opcode, id_funct;
   logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr;
   logic [31:0] id_rs_data, id_rt_data;
   logic [15:0] id_imm;
   logic        exm_reg_write, wb_reg_write;
   logic [4:0]  exm_rd, wb_rd;
   logic [31:0] exm_result, wb_result;
   logic        ex_stall, flush;
   logic        ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal;
   logic [31:0] ex_a, ex_b, ex_store_data;
   logic [2:0]  ex_sel;
   logic [4:0]  ex_rd;
`ifdef ID_EX_STALL_CNT_EN
   logic [31:0] stall_cnt;
`endif

   int n_vec = 0;
   int n_err = 0;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n),
      .id_valid(id_valid), .id_ready(id_ready),
      .id_opcode(id_opcode), .id_funct(id_funct),
      .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
      .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
      .exm_reg_write(exm_reg_write), .exm_rd(exm_rd), .exm_result(exm_result),
      .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
      .ex_stall(ex_stall), .flush(flush),
`ifdef ID_EX_STALL_CNT_EN
      .stall_cnt(stall_cnt),
`endif
      .ex_valid(ex_valid), .ex_a(ex_a), .ex_b(ex_b), .ex_sel(ex_sel),
      .ex_store_data(ex_store_data), .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_illegal(ex_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [5:0] op, input logic [5:0] fn,
                        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic [31:0] rsd, input logic [31:0] rtd, input logic [15:0] imm);
      id_valid   = 1'b1;
      id_opcode  = op;
      id_funct   = fn;
      id_rs_addr = rs;
      id_rt_addr = rt;
      id_rd_addr = rd;
      id_rs_data = rsd;
      id_rt_data = rtd;
      id_imm     = imm;
   endtask

   task automatic rise();
      @(posedge clk);
      #1;
   endtask

   task automatic fall();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b1;
      id_valid = 1'b0; id_opcode = '0; id_funct = '0;
      id_rs_addr = '0; id_rt_addr = '0; id_rd_addr = '0;
      id_rs_data = '0; id_rt_data = '0; id_imm = '0;
      exm_reg_write = 1'b0; exm_rd = '0; exm_result = '0;
      wb_reg_write = 1'b0; wb_rd = '0; wb_result = '0;
      ex_stall = 1'b0; flush = 1'b0;

      // Asynchronous reset asserted between clock edges.
      #2 rst_n = 1'b0;
      #1;
      check("rst_valid", ex_valid, 0);
      check("rst_a", ex_a, 0);
      check("rst_b", ex_b, 0);
      check("rst_sel", ex_sel, 0);
      check("rst_ctl", {ex_reg_write, ex_mem_read, ex_mem_write, ex_illegal}, 0);
      check("rst_rd", ex_rd, 0);
      check("rst_store", ex_store_data, 0);
      check("rst_ready", id_ready, 1);
      fall(); rst_n = 1'b1;

      // add r3 = r1(2) + r2(6)
      drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'd2, 32'd6, 16'h0);
      rise();
      check("add_valid", ex_valid, 1);
      check("add_a", ex_a, 2);
      check("add_b", ex_b, 6);
      check("add_sel", ex_sel, 3'b100);
      check("add_rd", ex_rd, 3);
      check("add_we", ex_reg_write, 1);
      check("add_sum", ex_a + ex_b, 8);

      // addi sign extension
      fall(); drive(6'h08, 6'h00, 5'd5, 5'd7, 5'd0, 32'd5, 32'd0, 16'hFFFF);
      rise();
      check("addi_a", ex_a, 5);
      check("addi_b", ex_b, 32'hFFFF_FFFF);
      check("addi_sel", ex_sel, 3'b100);
      check("addi_rd", ex_rd, 7);
      check("addi_we", ex_reg_write, 1);

      // ori zero extension
      fall(); drive(6'h0D, 6'h00, 5'd5, 5'd7, 5'd0, 32'd5, 32'd0, 16'hFFFF);
      rise();
      check("ori_b", ex_b, 32'h0000_FFFF);
      check("ori_sel", ex_sel, 3'b001);

      // andi zero extension of a negative-looking immediate
      fall(); drive(6'h0C, 6'h00, 5'd5, 5'd7, 5'd0, 32'd5, 32'd0, 16'h8000);
      rise();
      check("andi_b", ex_b, 32'h0000_8000);
      check("andi_sel", ex_sel, 3'b000);

      // xor R-type
      fall(); drive(6'h00, 6'h26, 5'd1, 5'd2, 5'd9, 32'hF0, 32'h0F, 16'h0);
      rise();
      check("xor_sel", ex_sel, 3'b110);
      check("xor_rd", ex_rd, 9);

      // Forwarding priority: EX/MEM over MEM/WB
      fall();
      exm_reg_write = 1'b1; exm_rd = 5'd3; exm_result = 32'd15;
      wb_reg_write  = 1'b1; wb_rd  = 5'd3; wb_result  = 32'd7;
      drive(6'h00, 6'h20, 5'd3, 5'd3, 5'd8, 32'd99, 32'd98, 16'h0);
      rise();
      check("fwd_exm_a", ex_a, 15);
      check("fwd_exm_b", ex_b, 15);
      fall(); exm_reg_write = 1'b0;
      rise();
      check("fwd_wb_a", ex_a, 7);
      fall(); exm_reg_write = 1'b1; exm_rd = 5'd0; wb_rd = 5'd0;
      drive(6'h00, 6'h20, 5'd0, 5'd0, 5'd8, 32'd99, 32'd44, 16'h0);
      rise();
      check("fwd_r0_a", ex_a, 99);
      check("fwd_r0_b", ex_b, 44);
      fall(); exm_reg_write = 1'b0; wb_reg_write = 1'b0;

      // Destination r0 never writes
      drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd0, 32'd1, 32'd1, 16'h0);
      rise();
      check("r0_we", ex_reg_write, 0);

      // sw: store data is rt, no register write
      fall(); drive(6'h2B, 6'h00, 5'd1, 5'd2, 5'd0, 32'd16, 32'h0000_ABCD, 16'hFFFC);
      rise();
      check("sw_b", ex_b, 32'hFFFF_FFFC);
      check("sw_store", ex_store_data, 32'h0000_ABCD);
      check("sw_ctl", {ex_reg_write, ex_mem_read, ex_mem_write}, 3'b001);

      // beq: SUB with b = rt, no write
      fall(); drive(6'h04, 6'h00, 5'd1, 5'd2, 5'd0, 32'd10, 32'd20, 16'h0004);
      rise();
      check("beq_sel", ex_sel, 3'b101);
      check("beq_b", ex_b, 20);
      check("beq_we", ex_reg_write, 0);

      // lw followed by an I-type whose rt is only a destination: no hazard
      fall(); drive(6'h23, 6'h00, 5'd1, 5'd4, 5'd0, 32'd100, 32'd0, 16'h0008);
      rise();
      check("lw_ctl", {ex_valid, ex_mem_read, ex_reg_write}, 3'b111);
      check("lw_rd", ex_rd, 4);
      check("lw_b", ex_b, 8);
      fall(); drive(6'h08, 6'h00, 5'd1, 5'd4, 5'd0, 32'd1, 32'd0, 16'h0001);
      #1 check("lw_rt_dest_ready", id_ready, 1);

      // lw r4 then sub using r4: one bubble, then forwarded capture
      rise();
      fall(); drive(6'h23, 6'h00, 5'd1, 5'd4, 5'd0, 32'd100, 32'd0, 16'h0008);
      rise();
      fall();
      exm_reg_write = 1'b1; exm_rd = 5'd4; exm_result = 32'd42;
      drive(6'h00, 6'h22, 5'd4, 5'd2, 5'd5, 32'd0, 32'd3, 16'h0);
      #1 check("lu_ready_lo", id_ready, 0);
      rise();
      check("lu_bubble", ex_valid, 0);
      check("lu_bubble_mr", ex_mem_read, 0);
      fall();
      #1 check("lu_ready_hi", id_ready, 1);
      rise();
      check("lu_sub_valid", ex_valid, 1);
      check("lu_sub_a", ex_a, 42);
      check("lu_sub_b", ex_b, 3);
      check("lu_sub_sel", ex_sel, 3'b101);
      fall(); exm_reg_write = 1'b0;

      // Stall three cycles: contents hold, id_ready low
      ex_stall = 1'b1;
      drive(6'h08, 6'h00, 5'd1, 5'd7, 5'd0, 32'd1234, 32'd0, 16'h0001);
      for (int i = 0; i < 3; i++) begin
         #1 check("stall_ready", id_ready, 0);
         rise();
         check("stall_valid", ex_valid, 1);
         check("stall_a", ex_a, 42);
         fall();
      end

      // Flush beats stall
      flush = 1'b1; id_valid = 1'b0;
      rise();
      check("flush_stall_valid", ex_valid, 0);
      check("flush_stall_we", ex_reg_write, 0);
`ifdef ID_EX_STALL_CNT_EN
      check("stall_cnt", stall_cnt, 4);
`endif
      fall(); flush = 1'b0; ex_stall = 1'b0;

      // Flush beats a pending capture
      flush = 1'b1;
      drive(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'd1, 32'd1, 16'h0);
      rise();
      check("flush_cap_valid", ex_valid, 0);
      fall(); flush = 1'b0;

      // Unsupported funct
      drive(6'h00, 6'h3F, 5'd1, 5'd2, 5'd6, 32'd1, 32'd1, 16'h0);
      rise();
      check("ill_flag", ex_illegal, 1);
      check("ill_we", ex_reg_write, 0);
      check("ill_sel", ex_sel, 3'b100);
      check("ill_valid", ex_valid, 1);

      // No instruction offered: bubble clears controls
      fall(); id_valid = 1'b0;
      rise();
      check("idle_valid", ex_valid, 0);
      check("idle_ill", ex_illegal, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
